// File: rtl/feistel_round_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feistel_round_engine_pkg
// Description : Shared widths, defaults, state codes, S-box and rotate helpers
//               for the Feistel round engine and its f-function.
// Revision    : 1.0 - initial release
// ============================================================================
package feistel_round_engine_pkg;

    localparam int c_block_w = 64;
    localparam int c_half_w  = 32;
    localparam int c_key_w   = 64;

    localparam int c_nrounds_dflt = 16;
    localparam int c_key_rot_dflt = 3;
    localparam int c_f_rot_dflt   = 5;

    // Bit 0 is the MSB throughout the datapath.
    typedef logic [0:c_block_w-1] block_t;
    typedef logic [0:c_half_w-1]  half_t;
    typedef logic [0:c_key_w-1]   key_t;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_round = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    function automatic logic [3:0] sbox4(input logic [3:0] n);
        logic [3:0] v;
        case (n)
            4'h0: v = 4'hC;
            4'h1: v = 4'h5;
            4'h2: v = 4'h6;
            4'h3: v = 4'hB;
            4'h4: v = 4'h9;
            4'h5: v = 4'h0;
            4'h6: v = 4'hA;
            4'h7: v = 4'hD;
            4'h8: v = 4'h3;
            4'h9: v = 4'hE;
            4'hA: v = 4'hF;
            4'hB: v = 4'h8;
            4'hC: v = 4'h4;
            4'hD: v = 4'h7;
            4'hE: v = 4'h1;
            default: v = 4'h2;
        endcase
        return v;
    endfunction

    function automatic half_t rotl32(input half_t x, input int k);
        int m;
        m = k % c_half_w;
        if (m == 0) return x;
        return (x << m) | (x >> (c_half_w - m));
    endfunction

    function automatic key_t rotl64(input key_t x, input int k);
        int m;
        m = k % c_key_w;
        if (m == 0) return x;
        return (x << m) | (x >> (c_key_w - m));
    endfunction

endpackage
`default_nettype wire

// File: rtl/feistel_round_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : feistel_round_engine_if
// Description : Block-in / block-out handshake bundle of the Feistel engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface feistel_round_engine_if;
    import feistel_round_engine_pkg::*;

    logic   start;
    logic   in_ready;
    block_t data_in;
    key_t   key_in;
    logic   busy;
    logic   out_valid;
    logic   out_ready;
    block_t data_out;

    modport master (
        output start,
        output data_in,
        output key_in,
        output out_ready,
        input  in_ready,
        input  busy,
        input  out_valid,
        input  data_out
    );

    modport slave (
        input  start,
        input  data_in,
        input  key_in,
        input  out_ready,
        output in_ready,
        output busy,
        output out_valid,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/feistel_round_engine_f.sv
`default_nettype none
// ============================================================================
// Module      : feistel_f
// Description : Combinational round function f(R,K) = rotl32(SBOX(R ^ K), F_ROT).
// Revision    : 1.0 - initial release
// ============================================================================
module feistel_f
    import feistel_round_engine_pkg::*;
#(
    parameter int F_ROT = c_f_rot_dflt
) (
    input  half_t i_r,
    input  half_t i_k,
    output half_t o_f
);
    half_t w_t;
    half_t w_s;

    assign w_t = i_r ^ i_k;

    // Each nibble is substituted independently, so lane order is immaterial.
    for (genvar gi = 0; gi < c_half_w / 4; gi++) begin : g_sbox
        assign w_s[4*gi +: 4] = sbox4(w_t[4*gi +: 4]);
    end

    assign o_f = rotl32(w_s, F_ROT);
endmodule
`default_nettype wire

// File: rtl/feistel_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : feistel_round_engine
// Description : Iterative Feistel core, one round per clock with rolling key.
// Revision    : 1.0 - initial release
// ============================================================================
module feistel_round_engine
    import feistel_round_engine_pkg::*;
#(
    parameter int NROUNDS = c_nrounds_dflt,
    parameter int KEY_ROT = c_key_rot_dflt,
    parameter int F_ROT   = c_f_rot_dflt
) (
    input  logic                   clk,
    input  logic                   rst,
    feistel_round_engine_if.slave  bus
);
    localparam int                 c_rnd_w    = $clog2(NROUNDS) + 1;
    localparam logic [c_rnd_w-1:0] c_rnd_last = c_rnd_w'(NROUNDS - 1);
    localparam logic [c_rnd_w-1:0] c_rnd_one  = c_rnd_w'(1);

    logic [1:0]         r_state;
    half_t              r_l;
    half_t              r_r;
    key_t               r_key;
    logic [c_rnd_w-1:0] r_rnd;
    block_t             r_data_out;

    half_t              w_f;
    half_t              w_r_next;

    feistel_f #(
        .F_ROT (F_ROT)
    ) u_f (
        .i_r (r_r),
        .i_k (r_key[0:c_half_w-1]),
        .o_f (w_f)
    );

    assign w_r_next = r_l ^ w_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_l        <= '0;
            r_r        <= '0;
            r_key      <= '0;
            r_rnd      <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.start) begin
                        r_l     <= bus.data_in[0:c_half_w-1];
                        r_r     <= bus.data_in[c_half_w:c_block_w-1];
                        r_key   <= bus.key_in;
                        r_rnd   <= '0;
                        r_state <= c_st_round;
                    end
                end
                c_st_round: begin
                    r_l   <= r_r;
                    r_r   <= w_r_next;
                    r_key <= rotl64(r_key, KEY_ROT);
                    r_rnd <= r_rnd + c_rnd_one;
                    // Final halves are emitted swapped: {R_N, L_N}.
                    if (r_rnd == c_rnd_last) begin
                        r_data_out <= {w_r_next, r_r};
                        r_state    <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_st_idle);
    assign bus.busy      = (r_state == c_st_round);
    assign bus.out_valid = (r_state == c_st_done);
    assign bus.data_out  = r_data_out;
endmodule
`default_nettype wire
